alu_mc: RTL and testbench

Multi-cycle successor to the single-cycle datapath ALU, parametrised in width. It adds EOR, LSL, LSR and a sequential shift-add MUL, plus a persistent NZCV flags register updated on request. It uses a valid/ready handshake on input and output, so the processor can stall on multi-cycle operations. It sits between the register-file read stage and the writeback mux.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_mc.sv | 193 +++++++++++++++++++
 tb/tb_alu_mc.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, NZCV bit positions and FSM states.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// done and product are combinational during the last iteration so the caller can load them.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic             busy_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   // Only the low WIDTH bits of the product are kept, so a WIDTH-bit accumulator suffices.
   assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done    = busy_q && (cnt_q == LastCnt);
   assign busy    = busy_q;
   assign product = acc_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, persistent NZCV register and optional
// sequential multiplier.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluctrl,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [3:0]       flags
);

   state_e           state_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic [3:0]       flags_q;
   logic             out_valid_q;
   logic             setf_q;

   logic             accept;
   logic             is_mul;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic [7:0]       amt;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH:0]   lsl_ext;
   logic [WIDTH:0]   lsr_ext;
   logic [WIDTH-1:0] op_res;
   logic             op_c;
   logic             op_v;
   logic             op_c_upd;
   logic             op_v_upd;

   logic [WIDTH-1:0] fin_res;
   logic             fin_setf;
   logic             fin_c_upd;
   logic             fin_v_upd;
   logic [3:0]       flags_d;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (aluctrl == OP_MUL) && (MUL_EN != 0);
   assign mul_start = accept && is_mul && !mul_busy;

   assign result    = result_q;
   assign zero      = zero_q;
   assign flags     = flags_q;
   assign out_valid = out_valid_q;

   if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(
         .WIDTH(WIDTH)
      ) u_mul (
         .clk    (clk),
         .reset_n(reset_n),
         .start  (mul_start),
         .a      (a),
         .b      (b),
         .busy   (mul_busy),
         .done   (mul_done),
         .product(mul_product)
      );
   end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
   end

   // Extended shifts: the extra bit catches the last bit shifted out, and any
   // amount above WIDTH naturally yields result 0 with carry 0.
   always_comb begin
      amt      = b[7:0];
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      lsl_ext  = {1'b0, a} << amt;
      lsr_ext  = {a, 1'b0} >> amt;
      op_res   = '0;
      op_c     = 1'b0;
      op_v     = 1'b0;
      op_c_upd = 1'b0;
      op_v_upd = 1'b0;
      unique case (aluctrl)
         OP_ADD: begin
            op_res   = sum_ext[WIDTH-1:0];
            op_c     = sum_ext[WIDTH];
            op_v     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            op_c_upd = 1'b1;
            op_v_upd = 1'b1;
         end
         OP_SUB: begin
            op_res   = diff_ext[WIDTH-1:0];
            op_c     = diff_ext[WIDTH];
            op_v     = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            op_c_upd = 1'b1;
            op_v_upd = 1'b1;
         end
         OP_AND: op_res = a & b;
         OP_ORR: op_res = a | b;
         OP_EOR: op_res = a ^ b;
         OP_LSL: begin
            op_res   = lsl_ext[WIDTH-1:0];
            op_c     = lsl_ext[WIDTH];
            op_c_upd = (amt != 8'd0);
         end
         OP_LSR: begin
            op_res   = lsr_ext[WIDTH:1];
            op_c     = lsr_ext[0];
            op_c_upd = (amt != 8'd0);
         end
         OP_MUL: op_res = '0;
      endcase
   end

   always_comb begin
      if (state_q == MUL) begin
         fin_res   = mul_product;
         fin_setf  = setf_q;
         fin_c_upd = 1'b0;
         fin_v_upd = 1'b0;
      end else begin
         fin_res   = op_res;
         fin_setf  = set_flags;
         fin_c_upd = op_c_upd;
         fin_v_upd = op_v_upd;
      end
      flags_d = flags_q;
      if (fin_setf) begin
         flags_d[FLAG_N] = fin_res[WIDTH-1];
         flags_d[FLAG_Z] = (fin_res == '0);
         if (fin_c_upd) flags_d[FLAG_C] = op_c;
         if (fin_v_upd) flags_d[FLAG_V] = op_v;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         zero_q      <= 1'b1;
         flags_q     <= 4'b0000;
         out_valid_q <= 1'b0;
         setf_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (accept && is_mul) begin
                  state_q     <= MUL;
                  out_valid_q <= 1'b0;
                  setf_q      <= set_flags;
               end else if (accept) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= fin_res;
                  zero_q      <= (fin_res == '0);
                  flags_q     <= flags_d;
               end else if ((state_q == DONE) && out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            MUL: begin
               if (mul_done) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= fin_res;
                  zero_q      <= (fin_res == '0);
                  flags_q     <= flags_d;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32, multiplier present).
module tb_alu_mc;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, ORR = 3'b011;
   localparam logic [2:0] EOR = 3'b100, LSL = 3'b101, LSR = 3'b110, MULOP = 3'b111;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  aluctrl;
   logic        set_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_errors = 0;

   alu_mc #(
      .WIDTH (32),
      .MUL_EN(1)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .aluctrl  (aluctrl),
      .set_flags(set_flags),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .zero     (zero),
      .flags    (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One non-MUL op with out_ready=1: result must appear right after the accept edge.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] opa,
                         input logic [31:0] opb, input logic sf, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags);
      check({tag, "_rdy"}, 64'(in_ready), 64'd1);
      a = opa; b = opb; aluctrl = op; set_flags = sf; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_res"}, 64'(result), 64'(exp_res));
      check({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'd0));
      check({tag, "_flags"}, 64'(flags), 64'(exp_flags));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ok;
      reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; aluctrl = ADD; set_flags = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_res", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_flags", 64'(flags), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();

      run_op("add", ADD, 32'd10, 32'd15, 1'b1, 32'd25, 4'b0000);
      run_op("sub_neg", SUB, 32'd10, 32'd15, 1'b1, 32'hFFFF_FFFB, 4'b1000);
      run_op("sub_eq", SUB, 32'd15, 32'd15, 1'b1, 32'd0, 4'b0110);
      run_op("and", AND_, 32'd10, 32'd15, 1'b0, 32'd10, 4'b0110);
      run_op("orr", ORR, 32'd10, 32'd15, 1'b0, 32'd15, 4'b0110);
      run_op("eor", EOR, 32'd10, 32'd15, 1'b0, 32'd5, 4'b0110);
      run_op("lsl1", LSL, 32'h8000_0000, 32'd1, 1'b1, 32'd0, 4'b0110);
      run_op("lsr0", LSR, 32'h0000_00F0, 32'd0, 1'b1, 32'h0000_00F0, 4'b0010);
      run_op("lsl40", LSL, 32'h0000_0001, 32'd40, 1'b1, 32'd0, 4'b0100);
      run_op("lsl32", LSL, 32'h0000_0001, 32'd32, 1'b1, 32'd0, 4'b0110);
      run_op("lsr1", LSR, 32'h0000_00F1, 32'd1, 1'b1, 32'h0000_0078, 4'b0010);
      run_op("add_ovf", ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 4'b1001);
      run_op("add_carry", ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b0110);

      // Back-to-back: in_valid held high, one result per cycle.
      a = 32'd1; b = 32'd2; aluctrl = ADD; set_flags = 1'b0; in_valid = 1'b1;
      tick();
      check("b2b0_valid", 64'(out_valid), 64'd1);
      check("b2b0_res", 64'(result), 64'd3);
      check("b2b0_rdy", 64'(in_ready), 64'd1);
      a = 32'd5; b = 32'd6;
      tick();
      check("b2b1_res", 64'(result), 64'd11);
      a = 32'd20; b = 32'd4; aluctrl = SUB;
      tick();
      check("b2b2_res", 64'(result), 64'd16);
      check("b2b2_flags", 64'(flags), 64'b0110);
      in_valid = 1'b0;
      tick();
      check("b2b_idle", 64'(out_valid), 64'd0);

      // MUL latency: 33 edges from accept to out_valid, in_ready low meanwhile.
      a = 32'd1234; b = 32'd5678; aluctrl = MULOP; set_flags = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 32'd99; b = 32'd99;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
         tick();
      end
      check("mul_busy_hold", 64'(ok), 64'd1);
      check("mul_valid", 64'(out_valid), 64'd1);
      check("mul_res", 64'(result), 64'd7006652);
      check("mul_flags", 64'(flags), 64'b0010);
      tick();

      // Backpressure: result held while out_ready is low; offered op is ignored.
      out_ready = 1'b0;
      a = 32'h55; b = 32'hAA; aluctrl = ORR; set_flags = 1'b1; in_valid = 1'b1;
      tick();
      a = 32'd0; b = 32'd0; aluctrl = AND_;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hFF ||
             flags !== 4'b0010) ok = 1'b0;
         tick();
      end
      check("bp_stable", 64'(ok), 64'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp_rdy_follow", 64'(in_ready), 64'd1);
      tick();
      check("bp_drain", 64'(out_valid), 64'd0);
      check("bp_res_keep", 64'(result), 64'hFF);

      // Reset during MUL discards the operation.
      a = 32'd3; b = 32'd5; aluctrl = MULOP; set_flags = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset_n = 1'b0;
      #2;
      check("rmul_valid", 64'(out_valid), 64'd0);
      check("rmul_flags", 64'(flags), 64'd0);
      check("rmul_res", 64'(result), 64'd0);
      tick();
      reset_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0) ok = 1'b0;
         tick();
      end
      check("rmul_no_ghost", 64'(ok), 64'd1);
      run_op("post_rst_add", ADD, 32'd3, 32'd4, 1'b0, 32'd7, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
